// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: CPU fetch port, CPU data port,
// the shared downstream memory port, and the pipeline stall.
//   slave  : arbiter view (takes CPU requests, drives memory requests)
//   master : environment view (CPU and memory side together)
interface mem_port_arbiter_if;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [2:0]  d_width;
  logic        d_ready;
  logic [63:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [2:0]  m_width;
  logic        m_ack;
  logic [63:0] m_rdata;

  logic        stall;

  modport slave (
    input  i_req, i_addr,
    output i_ready, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_width,
    output d_ready, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_width,
    input  m_ack, m_rdata,
    output stall
  );

  modport master (
    output i_req, i_addr,
    input  i_ready, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_width,
    input  d_ready, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_width,
    output m_ack, m_rdata,
    input  stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU fetch and load/store traffic onto one
// single-ported memory interface. Data wins by default; after STARVE_LIMIT
// consecutive data grants with a fetch pending, the fetch is forced through.
// Optional feature macro: ARB_PERF_EN adds grant and stall-cycle counters.
//
// state  | meaning
// IDLE   | waiting for a request; grant decision made here
// BUSY_I | fetch in flight downstream, waiting for m_ack
// BUSY_D | data access in flight downstream, waiting for m_ack
// RESP   | one-cycle ready pulse to the owner, no grant made
module mem_port_arbiter #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [2:0] FETCH_WIDTH  = 3'b010
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]        perf_i_grants,
  output logic [31:0]        perf_d_grants,
  output logic [31:0]        perf_stall_cycles
`endif
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   starve_cnt;
  logic               starve_max;
  logic               grant_i;
  logic               grant_d;
  logic               stall;

  logic               m_req;
  logic               m_we;
  logic [63:0]        m_addr;
  logic [63:0]        m_wdata;
  logic [2:0]         m_width;
  logic               i_ready;
  logic [31:0]        i_rdata;
  logic               d_ready;
  logic [63:0]        d_rdata;

  assign starve_max = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Grant decision, only meaningful in IDLE
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (bus.d_req && !(bus.i_req && starve_max)) begin
        grant_d = 1'b1;
      end else if (bus.i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Arbitration FSM with registered downstream request and responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_width    <= '0;
      i_ready    <= 1'b0;
      i_rdata    <= '0;
      d_ready    <= 1'b0;
      d_rdata    <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            m_req   <= 1'b1;
            m_we    <= bus.d_we;
            m_addr  <= bus.d_addr;
            m_wdata <= bus.d_wdata;
            m_width <= bus.d_width;
            state   <= BUSY_D;
            if (!bus.i_req) begin
              starve_cnt <= '0;
            end else if (!starve_max) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end else if (grant_i) begin
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= bus.i_addr;
            m_wdata    <= '0;
            m_width    <= FETCH_WIDTH;
            state      <= BUSY_I;
            starve_cnt <= '0;
          end
        end
        BUSY_I: begin
          if (bus.m_ack) begin
            m_req   <= 1'b0;
            i_rdata <= bus.m_rdata[31:0];
            i_ready <= 1'b1;
            state   <= RESP;
          end
        end
        BUSY_D: begin
          if (bus.m_ack) begin
            m_req   <= 1'b0;
            d_rdata <= bus.m_rdata;
            d_ready <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign stall = (bus.i_req & ~i_ready) | (bus.d_req & ~d_ready);

  assign bus.m_req   = m_req;
  assign bus.m_we    = m_we;
  assign bus.m_addr  = m_addr;
  assign bus.m_wdata = m_wdata;
  assign bus.m_width = m_width;
  assign bus.i_ready = i_ready;
  assign bus.i_rdata = i_rdata;
  assign bus.d_ready = d_ready;
  assign bus.d_rdata = d_rdata;
  assign bus.stall   = stall;

`ifdef ARB_PERF_EN
  // Free-running wrapping event counters for profiling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_i_grants     <= '0;
      perf_d_grants     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (grant_i) perf_i_grants <= perf_i_grants + 32'd1;
      if (grant_d) perf_d_grants <= perf_d_grants + 32'd1;
      if (stall)   perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a simple memory responder.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

`ifdef ARB_PERF_EN
  logic [31:0] perf_i_grants;
  logic [31:0] perf_d_grants;
  logic [31:0] perf_stall_cycles;
`endif

  mem_port_arbiter #(.STARVE_LIMIT(4), .FETCH_WIDTH(3'b010)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ARB_PERF_EN
    ,
    .perf_i_grants(perf_i_grants),
    .perf_d_grants(perf_d_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  int n_cmp;
  int n_err;

  bit          mem_en;
  int          mem_wait;
  logic [63:0] mem_rdata;
  int          spur_req;
  int          spur_done;
  int          wcnt;

  // Memory model: acks mem_wait cycles after m_req is seen; spur_req requests a stray ack
  initial begin
    bus.m_ack   = 1'b0;
    bus.m_rdata = '0;
    wcnt        = 0;
    spur_done   = 0;
    forever begin
      @(negedge clk);
      bus.m_ack = 1'b0;
      if (spur_done != spur_req) begin
        spur_done   = spur_req;
        bus.m_ack   = 1'b1;
        bus.m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end else if (mem_en && bus.m_req) begin
        if (wcnt >= mem_wait) begin
          bus.m_ack   = 1'b1;
          bus.m_rdata = mem_rdata;
          wcnt        = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    int rdy;
    int mreq_hi;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL reset_m_req got=%b want=0", bus.m_req); end
    n_cmp++; if (bus.m_we !== 1'b0) begin n_err++; $display("FAIL reset_m_we got=%b want=0", bus.m_we); end
    n_cmp++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL reset_i_ready got=%b want=0", bus.i_ready); end
    n_cmp++; if (bus.d_ready !== 1'b0) begin n_err++; $display("FAIL reset_d_ready got=%b want=0", bus.d_ready); end
    n_cmp++; if (bus.m_addr !== 64'h0) begin n_err++; $display("FAIL reset_m_addr got=%h want=0", bus.m_addr); end
    n_cmp++; if (bus.m_wdata !== 64'h0) begin n_err++; $display("FAIL reset_m_wdata got=%h want=0", bus.m_wdata); end
    n_cmp++; if (bus.m_width !== 3'b000) begin n_err++; $display("FAIL reset_m_width got=%b want=000", bus.m_width); end
    n_cmp++; if (bus.i_rdata !== 32'h0) begin n_err++; $display("FAIL reset_i_rdata got=%h want=0", bus.i_rdata); end
    n_cmp++; if (bus.d_rdata !== 64'h0) begin n_err++; $display("FAIL reset_d_rdata got=%h want=0", bus.d_rdata); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
    rst = 1'b0;
    tick();
    // Start a load with the memory silent, then reset while in BUSY_D
    mem_en      = 1'b0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 64'h3000;
    bus.d_width = 3'b011;
    tick();
    n_cmp++; if (bus.m_req !== 1'b1) begin n_err++; $display("FAIL rst_grant_m_req got=%b want=1", bus.m_req); end
    tick();
    n_cmp++; if (bus.m_req !== 1'b1) begin n_err++; $display("FAIL rst_busy_m_req got=%b want=1", bus.m_req); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL rst_async_m_req got=%b want=0", bus.m_req); end
    n_cmp++; if (bus.d_ready !== 1'b0) begin n_err++; $display("FAIL rst_async_d_ready got=%b want=0", bus.d_ready); end
    bus.d_req = 1'b0;
    tick();
    rst = 1'b0;
    spur_req++;
    rdy     = 0;
    mreq_hi = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.d_ready || bus.i_ready) rdy++;
      if (bus.m_req) mreq_hi++;
    end
    n_cmp++; if (rdy !== 0) begin n_err++; $display("FAIL rst_late_ack_ready got=%0d want=0", rdy); end
    n_cmp++; if (mreq_hi !== 0) begin n_err++; $display("FAIL rst_late_ack_m_req got=%0d want=0", mreq_hi); end
    mem_en = 1'b1;
  endtask

  task automatic test_single_fetch();
    mem_wait   = 0;
    mem_rdata  = 64'hFFFF_0000_0000_0013;
    bus.i_addr = 64'h1000;
    bus.i_req  = 1'b1;
    tick();
    n_cmp++; if (bus.m_req !== 1'b1) begin n_err++; $display("FAIL fetch_m_req got=%b want=1", bus.m_req); end
    n_cmp++; if (bus.m_addr !== 64'h1000) begin n_err++; $display("FAIL fetch_m_addr got=%h want=1000", bus.m_addr); end
    n_cmp++; if (bus.m_we !== 1'b0) begin n_err++; $display("FAIL fetch_m_we got=%b want=0", bus.m_we); end
    n_cmp++; if (bus.m_width !== 3'b010) begin n_err++; $display("FAIL fetch_m_width got=%b want=010", bus.m_width); end
    n_cmp++; if (bus.m_wdata !== 64'h0) begin n_err++; $display("FAIL fetch_m_wdata got=%h want=0", bus.m_wdata); end
    n_cmp++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL fetch_early_ready got=%b want=0", bus.i_ready); end
    n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall_busy got=%b want=1", bus.stall); end
    tick();
    n_cmp++; if (bus.i_ready !== 1'b1) begin n_err++; $display("FAIL fetch_i_ready got=%b want=1", bus.i_ready); end
    n_cmp++; if (bus.i_rdata !== 32'h0000_0013) begin n_err++; $display("FAIL fetch_i_rdata got=%h want=00000013", bus.i_rdata); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_resp got=%b want=0", bus.stall); end
    n_cmp++; if (bus.d_ready !== 1'b0) begin n_err++; $display("FAIL fetch_d_ready got=%b want=0", bus.d_ready); end
    bus.i_req = 1'b0;
    tick();
    n_cmp++; if (bus.i_ready !== 1'b0) begin n_err++; $display("FAIL fetch_pulse_width got=%b want=0", bus.i_ready); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_after got=%b want=0", bus.stall); end
    n_cmp++; if (bus.m_req !== 1'b0) begin n_err++; $display("FAIL fetch_m_req_after got=%b want=0", bus.m_req); end
  endtask

  task automatic test_store();
    int rd;
    int ri;
    mem_rdata   = 64'h5555_5555_5555_5555;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 64'h2008;
    bus.d_wdata = 64'hDEADBEEF;
    bus.d_width = 3'b011;
    tick();
    n_cmp++; if (bus.m_req !== 1'b1) begin n_err++; $display("FAIL store_m_req got=%b want=1", bus.m_req); end
    n_cmp++; if (bus.m_we !== 1'b1) begin n_err++; $display("FAIL store_m_we got=%b want=1", bus.m_we); end
    n_cmp++; if (bus.m_addr !== 64'h2008) begin n_err++; $display("FAIL store_m_addr got=%h want=2008", bus.m_addr); end
    n_cmp++; if (bus.m_wdata !== 64'hDEADBEEF) begin n_err++; $display("FAIL store_m_wdata got=%h want=deadbeef", bus.m_wdata); end
    n_cmp++; if (bus.m_width !== 3'b011) begin n_err++; $display("FAIL store_m_width got=%b want=011", bus.m_width); end
    rd = 0;
    ri = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.d_ready) begin
        rd++;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
      end
      if (bus.i_ready) ri++;
    end
    n_cmp++; if (rd !== 1) begin n_err++; $display("FAIL store_d_ready_pulses got=%0d want=1", rd); end
    n_cmp++; if (ri !== 0) begin n_err++; $display("FAIL store_i_ready_pulses got=%0d want=0", ri); end
  endtask

  task automatic test_contention();
    logic [9:0] got;
    int  ng;
    int  cyc;
    int  stall_bad;
    bit  prev;
    bit  done;
    mem_wait    = 0;
    mem_rdata   = 64'h0000_0000_0000_0093;
    bus.i_addr  = 64'h1000;
    bus.d_addr  = 64'h2000;
    bus.d_we    = 1'b0;
    bus.d_width = 3'b011;
    bus.i_req   = 1'b1;
    bus.d_req   = 1'b1;
    got       = '0;
    ng        = 0;
    cyc       = 0;
    stall_bad = 0;
    prev      = 1'b0;
    while (ng < 10 && cyc < 100) begin
      tick();
      cyc++;
      if (bus.stall !== 1'b1) stall_bad++;
      if (bus.m_req && !prev) begin
        got[ng] = (bus.m_addr == 64'h1000);
        ng++;
      end
      prev = bus.m_req;
    end
    n_cmp++; if (ng !== 10) begin n_err++; $display("FAIL contention_grant_count got=%0d want=10", ng); end
    // Bit k set means grant k went to fetch: expected D,D,D,D,I,D,D,D,D,I
    n_cmp++; if (got !== 10'b10_0001_0000) begin n_err++; $display("FAIL contention_order got=%b want=1000010000", got); end
    n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL contention_stall low_cycles=%0d want=0", stall_bad); end
    bus.d_req = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (bus.i_ready) begin
        bus.i_req = 1'b0;
        done = 1'b1;
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL contention_drain_timeout got=%b want=1", done); end
    tick();
    tick();
  endtask

  task automatic test_wait_states();
    int hi;
    int addr_bad;
    int rdy;
    int stray;
    mem_wait    = 5;
    mem_rdata   = 64'h1122_3344_5566_7788;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 64'h4000;
    bus.d_width = 3'b011;
    hi       = 0;
    addr_bad = 0;
    rdy      = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.m_req) begin
        hi++;
        if (bus.m_addr !== 64'h4000) addr_bad++;
      end
      if (bus.d_ready) begin
        rdy++;
        bus.d_req = 1'b0;
      end
    end
    // 5 wait cycles plus the ack cycle
    n_cmp++; if (hi !== 6) begin n_err++; $display("FAIL wait_m_req_cycles got=%0d want=6", hi); end
    n_cmp++; if (addr_bad !== 0) begin n_err++; $display("FAIL wait_m_addr_stable bad_cycles=%0d want=0", addr_bad); end
    n_cmp++; if (rdy !== 1) begin n_err++; $display("FAIL wait_ready_pulses got=%0d want=1", rdy); end
    n_cmp++; if (bus.d_rdata !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL wait_d_rdata got=%h want=1122334455667788", bus.d_rdata); end
    mem_wait = 0;
    spur_req++;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.i_ready || bus.d_ready || bus.m_req) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL spurious_ack_idle activity=%0d want=0", stray); end
    n_cmp++; if (bus.d_rdata !== 64'h1122_3344_5566_7788) begin n_err++; $display("FAIL spurious_ack_rdata got=%h want=1122334455667788", bus.d_rdata); end
  endtask

  task automatic test_drop_mid();
    int rd;
    int ri;
    mem_wait   = 2;
    mem_rdata  = 64'h0000_0000_CAFE_F00D;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 64'h5000;
    tick();
    bus.d_req = 1'b0;
    rd = 0;
    ri = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.d_ready) rd++;
      if (bus.i_ready) ri++;
    end
    n_cmp++; if (rd !== 1) begin n_err++; $display("FAIL drop_mid_ready got=%0d want=1", rd); end
    n_cmp++; if (ri !== 0) begin n_err++; $display("FAIL drop_mid_i_ready got=%0d want=0", ri); end
    n_cmp++; if (bus.d_rdata !== 64'h0000_0000_CAFE_F00D) begin n_err++; $display("FAIL drop_mid_rdata got=%h want=cafef00d", bus.d_rdata); end
    mem_wait = 0;
  endtask

`ifdef ARB_PERF_EN
  bit stall_mon_on;
  int stall_seen;

  // Counts stall-high cycles using the value held up to the next rising edge
  initial begin
    stall_seen = 0;
    forever begin
      @(negedge clk);
      #2;
      if (stall_mon_on && bus.stall) stall_seen++;
    end
  end

  task automatic run_txn(input bit is_d, input bit we, input logic [63:0] addr);
    bit done;
    if (is_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = addr;
      bus.d_width = 3'b011;
    end else begin
      bus.i_req  = 1'b1;
      bus.i_addr = addr;
    end
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (is_d ? bus.d_ready : bus.i_ready) begin
        done = 1'b1;
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL perf_txn_timeout addr=%h got=%b want=1", addr, done); end
    tick();
  endtask

  task automatic test_perf();
    int base;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_wait = 0;
    base = stall_seen;
    stall_mon_on = 1'b1;
    for (int k = 0; k < 10; k++) run_txn(1'b0, 1'b0, 64'h8000 + 64'(4 * k));
    for (int k = 0; k < 3; k++) run_txn(1'b1, 1'b1, 64'h9000 + 64'(8 * k));
    tick();
    stall_mon_on = 1'b0;
    tick();
    n_cmp++; if (perf_i_grants !== 32'd10) begin n_err++; $display("FAIL perf_i_grants got=%0d want=10", perf_i_grants); end
    n_cmp++; if (perf_d_grants !== 32'd3) begin n_err++; $display("FAIL perf_d_grants got=%0d want=3", perf_d_grants); end
    n_cmp++; if (perf_stall_cycles !== 32'(stall_seen - base)) begin n_err++; $display("FAIL perf_stall_vs_observed got=%0d want=%0d", perf_stall_cycles, stall_seen - base); end
    // Zero-wait transactions stall for the request cycle and the busy cycle: 13 * 2
    n_cmp++; if (perf_stall_cycles !== 32'd26) begin n_err++; $display("FAIL perf_stall_cycles got=%0d want=26", perf_stall_cycles); end
  endtask
`endif

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    spur_req    = 0;
    mem_en      = 1'b0;
    mem_wait    = 0;
    mem_rdata   = '0;
    rst         = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_width = '0;
`ifdef ARB_PERF_EN
    stall_mon_on = 1'b0;
`endif
    test_reset();
    test_single_fetch();
    test_store();
    test_contention();
    test_wait_states();
    test_drop_mid();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
